uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Memory-mapped, buffered UART transmitter; successor to the single-byte store-triggered UART path in the core.
- Adds a parametrised TX FIFO, a runtime-programmable baud divisor, configurable data and stop bits, and a readable status register, so software can poll instead of busy-waiting per byte.
- Sits behind the core's store/load address decode. The core asserts `we` for stores to the UART window and muxes `rdata` into `rd` for loads.

Parameters:
- DIV_DEFAULT, 868: reset value of the baud divisor, in clock cycles per bit.
- FIFO_DEPTH, 16: TX FIFO entries. Must be a power of 2, in the range 2..128.
- DATA_BITS, 8: data bits per frame, in the range 5..8.
- STOP_BITS, 1: stop bits per frame, 1 or 2.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous and active-low.
- we, input, 1: store strobe, already decoded for this block's window.
- addr, input, 2: word offset. 0 = TXDATA, 1 = STATUS, 2 = DIVISOR, 3 = reserved.
- wdata, input, 32: store data.
- rdata, output, 32: combinational read data for `addr`.
- uart_tx, output, 1: serial output. Registered; idles high.
- busy, output, 1: high while the FSM is not IDLE or the FIFO is not empty.

Behaviour:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-low, `rst_n`.
- Reset values:
  - uart_tx = 1, busy = 0.
  - FIFO empty, count = 0, overflow = 0.
  - divisor = DIV_DEFAULT, state = IDLE.
  - rdata follows `addr` combinationally.
- Register map:
  - TXDATA write: pushes wdata[DATA_BITS-1:0]. Upper bits are ignored.
  - TXDATA read: returns 0.
  - STATUS read:
    - bit0 busy
    - bit1 full
    - bit2 empty
    - bit3 overflow
    - bits[15:8] count
    - other bits 0
  - STATUS write: wdata[3] = 1 clears overflow. All other bits are ignored.
  - DIVISOR write: loads wdata[15:0]. A value of 0 is treated as 1.
  - DIVISOR read: returns the stored value, zero-extended.
  - Offset 3: reads 0; writes are ignored.
- Push rule: a push is accepted if the FIFO is not full, or if a pop happens at the same edge.
  - Full is the pre-edge value.
  - Simultaneous push and pop leaves count unchanged.
  - A rejected push sets overflow (sticky). Data and count are unchanged.
- Overflow set and clear cannot coincide: both are single writes to different offsets.
- FSM states and transitions:
  - IDLE: if FIFO not empty, pop into the shift register, load the baud counter, drive uart_tx = 0, go to START.
  - START: one bit time, then go to DATA with bit index 0.
  - DATA: shift out LSB first, one bit time per bit. After DATA_BITS bits go to STOP, with uart_tx = 1.
  - STOP: lasts STOP_BITS bit times. At the end:
    - FIFO not empty: pop, go directly to START. No idle gap; uart_tx goes low on the cycle after the last stop cycle.
    - Otherwise: go to IDLE.
- Bit timing:
  - A bit time is `divisor` clock cycles. The baud counter loads divisor-1 and counts down to 0.
  - The divisor is sampled at each bit boundary. A mid-bit write takes effect from the next bit.
- Latency: a TXDATA write at edge N into an empty FIFO with the FSM in IDLE gives uart_tx = 0 starting at edge N+1.
  - FIFO write-through: the first-word pop happens at edge N+1.
- Frame length: (1 + DATA_BITS + STOP_BITS) × divisor cycles.
- Reset mid-frame: uart_tx goes to 1 immediately. FIFO, counters and FSM clear asynchronously. No partial frame resumes after release.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum: IDLE, START, DATA, STOP.
  - Register offsets: ADDR_TXDATA, ADDR_STATUS, ADDR_DIVISOR.
  - Status bit indices: ST_BUSY, ST_FULL, ST_EMPTY, ST_OVF, ST_CNT_LSB.
- Sub-module sync_fifo, parametrised on WIDTH and DEPTH:
  - Ports: push, pop, din, dout, full, empty, count.
  - dout shows the head entry; pop is same-edge.
  - Count width is $clog2(DEPTH+1).
- Top level contains the FSM, baud counter and register file.

Test Plan:
Common configuration: DIV_DEFAULT=4, FIFO_DEPTH=4, DATA_BITS=8, STOP_BITS=1.
1. Reset: hold rst_n low for 3 cycles, then release -> uart_tx=1, busy=0, STATUS read = 0x00000004, DIVISOR read = 4.
2. Single byte: write TXDATA=0x55 at edge N -> uart_tx low over cycles N+1..N+4, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, stop high for 4 cycles. Total 40 cycles; busy falls at edge N+41; STATUS returns to 0x04.
3. Burst and overflow: write 6 bytes 0xA0..0xA5 on consecutive cycles -> the first is popped immediately and 0xA5 is rejected. STATUS shows overflow=1, full=1, count=4. Then 5 frames 0xA0..0xA4 go out back-to-back in 200 cycles, with no extra high cycle between a stop bit and the next start bit.
4. Overflow clear: after scenario 3, write STATUS=0x8 -> bit3 reads 0. Writing STATUS=0x0 instead leaves bit3 set.
5. Divisor change: write DIVISOR=8 during data bit 3 of 0xFF -> bit 3 keeps 4 cycles; bits 4..7 and stop last 8 cycles each. Then write DIVISOR=0 -> reads 0 and frames use 1 cycle per bit (10-cycle frame).
6. Reset mid-frame: pull rst_n low during data bit 2 with 2 bytes queued -> uart_tx=1 within the same cycle, before any clock edge. After release, STATUS=0x04 and uart_tx stays high for 100 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [1:0] ADDR_TXDATA  = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_DIVISOR = 2'd2;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  // A programmed divisor of zero still yields a one-cycle bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Store/load bus between the core's address decode and the UART register window.
interface uart_tx_fifo_if;

  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, addr, wdata, input rdata);
  modport slave  (input we, addr, wdata, output rdata);

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with a combinational head view; a push into a full FIFO
// is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: TX FIFO, programmable baud divisor,
// status register and the serialising FSM.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DIV_DEFAULT = 868,
  parameter int FIFO_DEPTH  = 16,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus,
  output logic           uart_tx,
  output logic           busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = $clog2(DATA_BITS);

  tx_state_t            state;
  logic [15:0]          divisor;
  logic [15:0]          baud_cnt;
  logic [15:0]          div_load;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 overflow;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;
  logic [CNT_W-1:0]     fifo_count;

  logic wr_txdata;
  logic wr_status;
  logic wr_divisor;
  logic bit_done;
  logic last_stop;
  logic unused_wdata;

  assign wr_txdata    = bus.we && (bus.addr == ADDR_TXDATA);
  assign wr_status    = bus.we && (bus.addr == ADDR_STATUS);
  assign wr_divisor   = bus.we && (bus.addr == ADDR_DIVISOR);
  assign bit_done     = (baud_cnt == 16'd0);
  assign last_stop    = (stop_idx == 1'(STOP_BITS - 1));
  assign div_load     = eff_div(divisor) - 16'd1;
  assign busy         = (state != IDLE) || !fifo_empty;
  assign unused_wdata = ^bus.wdata[31:16];

  // Pops happen on leaving IDLE or at the end of the final stop bit, so
  // queued frames chain without an idle gap.
  assign fifo_pop = !fifo_empty &&
                    ((state == IDLE) ||
                     ((state == STOP) && bit_done && last_stop));

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (bus.wdata[DATA_BITS-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor  <= 16'(DIV_DEFAULT);
      overflow <= 1'b0;
    end else begin
      if (wr_divisor) divisor <= bus.wdata[15:0];
      if (wr_txdata && fifo_full && !fifo_pop) overflow <= 1'b1;
      else if (wr_status && bus.wdata[ST_OVF]) overflow <= 1'b0;
    end
  end

  // The divisor is re-sampled into baud_cnt at every bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      uart_tx   <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            shift_reg <= fifo_dout;
            baud_cnt  <= div_load;
            uart_tx   <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= div_load;
            bit_idx  <= '0;
            uart_tx  <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= div_load;
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              stop_idx <= 1'b0;
              uart_tx  <= 1'b1;
              state    <= STOP;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= shift_reg >> 1;
              uart_tx   <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= div_load;
            if (last_stop) begin
              if (fifo_pop) begin
                shift_reg <= fifo_dout;
                uart_tx   <= 1'b0;
                state     <= START;
              end else begin
                state <= IDLE;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      ADDR_STATUS: begin
        bus.rdata[ST_BUSY]             = busy;
        bus.rdata[ST_FULL]             = fifo_full;
        bus.rdata[ST_EMPTY]            = fifo_empty;
        bus.rdata[ST_OVF]              = overflow;
        bus.rdata[ST_CNT_LSB +: 8]     = 8'(fifo_count);
      end
      ADDR_DIVISOR: bus.rdata[15:0] = divisor;
      default:      bus.rdata = '0;
    endcase
  end

endmodule
